// File: rtl/pulse_sweep_ctrl.sv
// Frequency-sweep scheduler: steps ctrl from f_start to f_stop, holding each value for max(dwell,1) cycles.
// ctrl/duty/done are registered (one-cycle latency from start/abort/config write); no backpressure, start ignored while busy.
module pulse_sweep_ctrl #(
   parameter int CW  = 32,
   parameter int DWW = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [2:0]    cfg_addr,
   input  logic [CW-1:0] cfg_data,
   input  logic          start,
   input  logic          abort,
   output logic [CW-1:0] ctrl,
   output logic [CW-1:0] duty,
   output logic          busy,
   output logic          done
);

   localparam logic [0:0]    S_IDLE   = 1'b0;
   localparam logic [0:0]    S_RUN    = 1'b1;
   localparam logic [CW-1:0] DUTY_RST = {1'b1, {(CW-1){1'b0}}};

   logic [CW-1:0]  fstart_q, fstop_q, fstep_q, duty_q;
   logic [DWW-1:0] dwell_q;
   logic [1:0]     mode_q;

   logic [CW-1:0]  sh_start_q, sh_stop_q, sh_step_q;
   logic [DWW-1:0] sh_dwell_q;
   logic           sh_loop_q, sh_bidir_q;

   logic [0:0]     state_q, state_d;
   logic [CW-1:0]  ctrl_q, ctrl_d;
   logic [CW-1:0]  target_q, target_d;
   logic [DWW-1:0] cnt_q, cnt_d;
   logic           up_q, up_d;
   logic           ret_q, ret_d;
   logic           done_q, done_d;
   logic           accept;
   logic [CW-1:0]  swap_tgt;

   // Counter preload so that a dwell of 0 behaves like a dwell of 1.
   function automatic logic [DWW-1:0] dwell_load(input logic [DWW-1:0] d);
      dwell_load = (d == '0) ? '0 : d - DWW'(1);
   endfunction

   // One step toward tgt, clamped on overshoot, carry or borrow.
   function automatic logic [CW-1:0] step_to(input logic [CW-1:0] cur,
                                              input logic [CW-1:0] stp,
                                              input logic [CW-1:0] tgt,
                                              input logic          up);
      logic [CW:0] nxt;
      step_to = tgt;
      if (up) begin
         nxt = {1'b0, cur} + {1'b0, stp};
         if (!nxt[CW] && nxt[CW-1:0] <= tgt && stp != '0) step_to = nxt[CW-1:0];
      end else begin
         nxt = {1'b0, cur} - {1'b0, stp};
         if (!nxt[CW] && nxt[CW-1:0] >= tgt && stp != '0) step_to = nxt[CW-1:0];
      end
   endfunction

   assign accept   = (state_q == S_IDLE) && start && !abort;
   assign swap_tgt = ret_q ? sh_stop_q : sh_start_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fstart_q <= '0;
         fstop_q  <= '0;
         fstep_q  <= '0;
         dwell_q  <= '0;
         duty_q   <= DUTY_RST;
         mode_q   <= '0;
      end else if (cfg_we) begin
         case (cfg_addr)
            3'd0:    fstart_q <= cfg_data;
            3'd1:    fstop_q  <= cfg_data;
            3'd2:    fstep_q  <= cfg_data;
            3'd3:    dwell_q  <= cfg_data[DWW-1:0];
            3'd4:    duty_q   <= cfg_data;
            3'd5:    mode_q   <= cfg_data[1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_start_q <= '0;
         sh_stop_q  <= '0;
         sh_step_q  <= '0;
         sh_dwell_q <= '0;
         sh_loop_q  <= 1'b0;
         sh_bidir_q <= 1'b0;
      end else if (accept) begin
         sh_start_q <= fstart_q;
         sh_stop_q  <= fstop_q;
         sh_step_q  <= fstep_q;
         sh_dwell_q <= dwell_q;
         sh_loop_q  <= mode_q[0];
         sh_bidir_q <= mode_q[1];
      end
   end

   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      up_d     = up_q;
      ret_d    = ret_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (abort) begin
               ctrl_d = '0;
            end else if (start) begin
               state_d  = S_RUN;
               ctrl_d   = fstart_q;
               target_d = fstop_q;
               up_d     = (fstop_q >= fstart_q);
               cnt_d    = dwell_load(dwell_q);
               ret_d    = 1'b0;
            end
         end
         default: begin
            if (abort) begin
               state_d = S_IDLE;
               ctrl_d  = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DWW'(1);
            end else begin
               cnt_d = dwell_load(sh_dwell_q);
               if (ctrl_q != target_q) begin
                  ctrl_d = step_to(ctrl_q, sh_step_q, target_q, up_q);
               end else if (sh_bidir_q && (sh_loop_q || !ret_q)) begin
                  // Ping-pong turnaround: the first step of the new segment happens on this edge.
                  target_d = swap_tgt;
                  up_d     = !up_q;
                  ret_d    = !ret_q;
                  ctrl_d   = step_to(ctrl_q, sh_step_q, swap_tgt, !up_q);
               end else if (!sh_bidir_q && sh_loop_q) begin
                  ctrl_d = sh_start_q;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ctrl_q   <= '0;
         target_q <= '0;
         cnt_q    <= '0;
         up_q     <= 1'b1;
         ret_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         up_q     <= up_d;
         ret_q    <= ret_d;
         done_q   <= done_d;
      end
   end

   assign ctrl = ctrl_q;
   assign duty = duty_q;
   assign busy = (state_q == S_RUN);
   assign done = done_q;

endmodule

// File: tb/tb_pulse_sweep_ctrl.sv
// Directed bench for pulse_sweep_ctrl: vector table of per-cycle expectations plus hand-written reset/latency sequences.
module tb_pulse_sweep_ctrl;

   logic        clk;
   logic        rst;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        start;
   logic        abort;
   logic [31:0] ctrl;
   logic [31:0] duty;
   logic        busy;
   logic        done;

   pulse_sweep_ctrl #(.CW(32), .DWW(24)) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .start    (start),
      .abort    (abort),
      .ctrl     (ctrl),
      .duty     (duty),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  addr;
      logic [31:0] data;
      logic        st;
      logic        ab;
      logic [31:0] ectrl;
      logic [31:0] eduty;
      logic        ebusy;
      logic        edone;
   } vec_t;

   vec_t        tbl[$];
   logic [31:0] m_ctrl;
   logic [31:0] m_duty;
   int          checks;
   int          errors;
   int          cyc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic [2:0] addr, input logic [31:0] data,
                      input logic st, input logic ab,
                      input logic [31:0] ectrl, input logic ebusy, input logic edone);
      vec_t v;
      if (we && addr == 3'd4) m_duty = data;
      m_ctrl  = ectrl;
      v.we    = we;
      v.addr  = addr;
      v.data  = data;
      v.st    = st;
      v.ab    = ab;
      v.ectrl = ectrl;
      v.eduty = m_duty;
      v.ebusy = ebusy;
      v.edone = edone;
      tbl.push_back(v);
   endtask

   task automatic addw(input logic [2:0] addr, input logic [31:0] data);
      add(1'b1, addr, data, 1'b0, 1'b0, m_ctrl, 1'b0, 1'b0);
   endtask

   task automatic addv(input logic st, input logic ab, input logic [31:0] ectrl,
                       input logic ebusy, input logic edone);
      add(1'b0, 3'd0, 32'd0, st, ab, ectrl, ebusy, edone);
   endtask

   task automatic wr(input logic [2:0] addr, input logic [31:0] data);
      cfg_we   = 1'b1;
      cfg_addr = addr;
      cfg_data = data;
      @(posedge clk);
      #1;
      cfg_we   = 1'b0;
   endtask

   task automatic build_table();
      m_ctrl = 32'd0;
      m_duty = 32'h8000_0000;
      // basic up sweep, dwell 2
      addw(3'd0, 32'd100); addw(3'd1, 32'd130); addw(3'd2, 32'd10);
      addw(3'd3, 32'd2);   addw(3'd5, 32'd0);
      addv(1, 0, 32'd100, 1, 0); addv(0, 0, 32'd100, 1, 0);
      addv(0, 0, 32'd110, 1, 0); addv(0, 0, 32'd110, 1, 0);
      addv(0, 0, 32'd120, 1, 0); addv(0, 0, 32'd120, 1, 0);
      addv(0, 0, 32'd130, 1, 0); addv(0, 0, 32'd130, 1, 0);
      addv(0, 0, 32'd130, 0, 1); addv(0, 0, 32'd130, 0, 0);
      addv(0, 1, 32'd0,   0, 0);
      // down sweep with clamp on borrow
      addw(3'd0, 32'h50); addw(3'd1, 32'h10); addw(3'd2, 32'h30); addw(3'd3, 32'd1);
      addv(1, 0, 32'h50, 1, 0); addv(0, 0, 32'h20, 1, 0);
      addv(0, 0, 32'h10, 1, 0); addv(0, 0, 32'h10, 0, 1);
      addv(0, 0, 32'h10, 0, 0);
      // carry-out clamp, dwell 0 treated as 1
      addw(3'd0, 32'hFFFF_FF00); addw(3'd1, 32'hFFFF_FFFF);
      addw(3'd2, 32'h200);       addw(3'd3, 32'd0);
      addv(1, 0, 32'hFFFF_FF00, 1, 0); addv(0, 0, 32'hFFFF_FFFF, 1, 0);
      addv(0, 0, 32'hFFFF_FFFF, 0, 1);
      // zero step jumps to target
      addw(3'd0, 32'd5); addw(3'd1, 32'd9); addw(3'd2, 32'd0); addw(3'd3, 32'd1);
      addv(1, 0, 32'd5, 1, 0); addv(0, 0, 32'd9, 1, 0); addv(0, 0, 32'd9, 0, 1);
      // start == stop held for one dwell
      addw(3'd0, 32'd7); addw(3'd1, 32'd7); addw(3'd3, 32'd2);
      addv(1, 0, 32'd7, 1, 0); addv(0, 0, 32'd7, 1, 0); addv(0, 0, 32'd7, 0, 1);
      // bidir + loop, then abort
      addw(3'd0, 32'd10); addw(3'd1, 32'd30); addw(3'd2, 32'd10);
      addw(3'd3, 32'd1);  addw(3'd5, 32'd3);
      addv(1, 0, 32'd10, 1, 0); addv(0, 0, 32'd20, 1, 0); addv(0, 0, 32'd30, 1, 0);
      addv(0, 0, 32'd20, 1, 0); addv(0, 0, 32'd10, 1, 0); addv(0, 0, 32'd20, 1, 0);
      addv(0, 0, 32'd30, 1, 0); addv(0, 0, 32'd20, 1, 0);
      addv(0, 1, 32'd0, 0, 0);  addv(0, 0, 32'd0, 0, 0); addv(0, 0, 32'd0, 0, 0);
      // bidir single pass ends after return to f_start
      addw(3'd5, 32'd2);
      addv(1, 0, 32'd10, 1, 0); addv(0, 0, 32'd20, 1, 0); addv(0, 0, 32'd30, 1, 0);
      addv(0, 0, 32'd20, 1, 0); addv(0, 0, 32'd10, 1, 0);
      addv(0, 0, 32'd10, 0, 1); addv(0, 0, 32'd10, 0, 0);
      // start and abort together from IDLE
      addv(1, 1, 32'd0, 0, 0); addv(0, 0, 32'd0, 0, 0);
      // restart ignored while busy; shadowed f_stop, live duty
      addw(3'd0, 32'd100); addw(3'd1, 32'd130); addw(3'd2, 32'd10);
      addw(3'd3, 32'd2);   addw(3'd5, 32'd0);
      addv(1, 0, 32'd100, 1, 0); addv(1, 0, 32'd100, 1, 0);
      addv(0, 0, 32'd110, 1, 0);
      add(1'b1, 3'd1, 32'd999, 1'b0, 1'b0, 32'd110, 1'b1, 1'b0);
      add(1'b1, 3'd4, 32'h4000_0000, 1'b0, 1'b0, 32'd120, 1'b1, 1'b0);
      addv(0, 0, 32'd120, 1, 0); addv(0, 0, 32'd130, 1, 0);
      addv(0, 0, 32'd130, 1, 0); addv(0, 0, 32'd130, 0, 1);
      addv(0, 0, 32'd130, 0, 0);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      cfg_we   = 1'b0;
      cfg_addr = 3'd0;
      cfg_data = 32'd0;
      start    = 1'b0;
      abort    = 1'b0;
      build_table();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("reset ctrl", ctrl, 32'd0);
      chk("reset duty", duty, 32'h8000_0000);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         cfg_we   = tbl[i].we;
         cfg_addr = tbl[i].addr;
         cfg_data = tbl[i].data;
         start    = tbl[i].st;
         abort    = tbl[i].ab;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d ctrl", i), ctrl, tbl[i].ectrl);
         chk($sformatf("vec%0d duty", i), duty, tbl[i].eduty);
         chk($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].ebusy});
         chk($sformatf("vec%0d done", i), {31'd0, done}, {31'd0, tbl[i].edone});
      end
      cfg_we = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;

      // done latency: 3 values x dwell 3 plus the final hold, counted from the start edge
      wr(3'd0, 32'd200); wr(3'd1, 32'd240); wr(3'd2, 32'd20);
      wr(3'd3, 32'd3);   wr(3'd5, 32'd0);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("done latency", cyc, 32'd10);
      chk("done ctrl", ctrl, 32'd240);
      chk("done busy", {31'd0, busy}, 32'd0);

      // asynchronous reset mid-dwell
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("pre-rst ctrl", ctrl, 32'd200);
      chk("pre-rst busy", {31'd0, busy}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst ctrl", ctrl, 32'd0);
      chk("async rst duty", duty, 32'h8000_0000);
      chk("async rst busy", {31'd0, busy}, 32'd0);
      chk("async rst done", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("post-rst ctrl", ctrl, 32'd0);
      chk("post-rst busy", {31'd0, busy}, 32'd0);

      // sweep with reset config: single value 0, one cycle, then done
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("rstcfg busy", {31'd0, busy}, 32'd1);
      chk("rstcfg ctrl", ctrl, 32'd0);
      @(posedge clk);
      #1;
      chk("rstcfg done", {31'd0, done}, 32'd1);
      chk("rstcfg idle", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
